// File: rtl/prog_loader_if.sv
// Byte-stream and RAM write-port bundle for the Thistle program loader.
// The master drives the stream; the slave (the loader) owns the RAM port.
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              program_mode;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [7:0]        instr_count;

  modport master (
    output program_mode,
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_addr,
    input  mem_data,
    input  mem_we,
    input  busy,
    input  done,
    input  error,
    input  err_code,
    input  instr_count
  );

  modport slave (
    input  program_mode,
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_addr,
    output mem_data,
    output mem_we,
    output busy,
    output done,
    output error,
    output err_code,
    output instr_count
  );
endinterface

// File: rtl/prog_loader.sv
// Thistle program loader: framed byte stream -> sequential RAM writes,
// with opcode/operand validation and a trailing mod-256 checksum.
module prog_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic          clk,
  input logic          rst,
  prog_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    WRITE,
    CSUM
  } state_e;

  state_e            state_q;
  logic              ready_q;
  logic              we_q;
  logic              done_q;
  logic              error_q;
  logic [1:0]        code_q;
  logic [7:0]        icnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [7:0]        mdata_q;
  logic [7:0]        cnt_q;
  logic [7:0]        sum_q;
  logic              pend_q;
  logic              bad_q;

  logic       pm;
  logic       xfer;
  logic [3:0] hi;
  logic       takes_op;

  assign pm   = bus.program_mode;
  assign xfer = bus.byte_valid & ready_q;
  assign hi   = bus.byte_in[7:4];

  // LD, ST, JC, JNC, JMP, JR carry one operand byte
  assign takes_op = (hi == 4'h0) || (hi == 4'h1)
                 || (hi == 4'h7) || (hi == 4'h8)
                 || (hi == 4'h9) || (hi == 4'hA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= 2'b00;
      icnt_q  <= 8'd0;
      addr_q  <= BASE_ADDR;
      maddr_q <= BASE_ADDR;
      mdata_q <= 8'd0;
      cnt_q   <= 8'd0;
      sum_q   <= 8'd0;
      pend_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ready_q <= pm;
          if (xfer) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            code_q  <= 2'b00;
            icnt_q  <= 8'd0;
            sum_q   <= 8'd0;
            pend_q  <= 1'b0;
            bad_q   <= 1'b0;
            cnt_q   <= bus.byte_in;
            addr_q  <= BASE_ADDR;
            if (bus.byte_in == 8'd0) begin
              error_q <= 1'b1;
              code_q  <= 2'b11;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (!pm) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            error_q <= 1'b1;
            code_q  <= 2'b11;
          end else if (xfer) begin
            mdata_q <= bus.byte_in;
            maddr_q <= addr_q;
            sum_q   <= sum_q + bus.byte_in;
            we_q    <= 1'b1;
            ready_q <= 1'b0;
            state_q <= WRITE;
            if (!pend_q) begin
              icnt_q <= icnt_q + 8'd1;
              pend_q <= takes_op;
              if (hi > 4'hD) begin
                bad_q <= 1'b1;
              end
            end else begin
              pend_q <= 1'b0;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        WRITE: begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q - 8'd1;
          // a drop during the write lets the write finish first
          if (!pm) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            error_q <= 1'b1;
            code_q  <= 2'b11;
          end else begin
            ready_q <= 1'b1;
            state_q <= (cnt_q == 8'd1) ? CSUM : DATA;
          end
        end
        CSUM: begin
          if (!pm) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            error_q <= 1'b1;
            code_q  <= 2'b11;
          end else if (xfer) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            if (bus.byte_in != sum_q) begin
              error_q <= 1'b1;
              code_q  <= 2'b01;
            end else if (bad_q) begin
              error_q <= 1'b1;
              code_q  <= 2'b10;
            end else if (pend_q) begin
              error_q <= 1'b1;
              code_q  <= 2'b11;
            end else begin
              done_q <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready  = ready_q;
  assign bus.mem_addr    = maddr_q;
  assign bus.mem_data    = mdata_q;
  assign bus.mem_we      = we_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.err_code    = code_q;
  assign bus.instr_count = icnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued as
// payload bytes are driven and retired as mem_we pulses appear.
module tb_prog_loader;

  localparam logic [7:0] BASE = 8'hFE;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prog_loader_if #(.ADDR_W(8)) bus ();

  prog_loader #(
    .ADDR_W   (8),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;

  logic [15:0] sb[$];
  logic [7:0]  pay[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // retire one scoreboard entry per write strobe
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && bus.mem_we) begin
      wr_cnt++;
      chk("rdy_in_wr", bus.byte_ready, 1'b0);
      if (sb.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", bus.mem_addr, e[15:8]);
        chk("wr_data", bus.mem_data, e[7:0]);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit rnd);
    int t;
    t = 0;
    @(negedge clk);
    if (rnd) begin
      for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
        bus.byte_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("hs_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] c, input bit rnd,
                           input int abort_at);
    logic [7:0] a;
    a = BASE;
    send(8'(pay.size()), rnd);
    foreach (pay[i]) begin
      if (i == abort_at) begin
        bus.program_mode = 1'b0;
        return;
      end
      sb.push_back({a, pay[i]});
      send(pay[i], rnd);
      a = a + 8'd1;
    end
    send(c, rnd);
  endtask

  task automatic res(input string t, input logic d, input logic e,
                     input logic [1:0] code, input logic [7:0] ic);
    chk({t, ".done"},  bus.done, d);
    chk({t, ".error"}, bus.error, e);
    chk({t, ".code"},  bus.err_code, code);
    chk({t, ".icnt"},  bus.instr_count, ic);
    chk({t, ".busy"},  bus.busy, 1'b0);
    chk({t, ".sb"},    sb.size(), 0);
  endtask

  task automatic reset_vals(input string t);
    chk({t, ".rdy"},   bus.byte_ready, 1'b0);
    chk({t, ".we"},    bus.mem_we, 1'b0);
    chk({t, ".busy"},  bus.busy, 1'b0);
    chk({t, ".done"},  bus.done, 1'b0);
    chk({t, ".error"}, bus.error, 1'b0);
    chk({t, ".code"},  bus.err_code, 2'b00);
    chk({t, ".icnt"},  bus.instr_count, 8'd0);
    chk({t, ".addr"},  bus.mem_addr, BASE);
    chk({t, ".data"},  bus.mem_data, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    bus.program_mode = 1'b0;
    bus.byte_in      = 8'd0;
    bus.byte_valid   = 1'b0;
    #22;
    reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;
    bus.program_mode = 1'b1;
    repeat (2) @(negedge clk);

    pay = '{8'h00, 8'h0A, 8'h60};
    run_frame(8'h6A, 1'b0, -1);
    res("valid", 1'b1, 1'b0, 2'b00, 8'd2);

    run_frame(8'h6B, 1'b0, -1);
    res("badsum", 1'b0, 1'b1, 2'b01, 8'd2);

    pay = '{8'hE0, 8'hD0};
    run_frame(8'hB0, 1'b0, -1);
    res("badop", 1'b0, 1'b1, 2'b10, 8'd2);

    pay = '{8'h90};
    run_frame(8'h90, 1'b0, -1);
    res("trunc", 1'b0, 1'b1, 2'b11, 8'd1);

    w0 = wr_cnt;
    pay = '{8'h10, 8'h22, 8'h33, 8'h44};
    run_frame(8'h00, 1'b0, 2);
    repeat (4) @(negedge clk);
    chk("abort.writes", wr_cnt - w0, 2);
    res("abort", 1'b0, 1'b1, 2'b11, 8'd1);
    bus.program_mode = 1'b1;
    repeat (2) @(negedge clk);
    pay = '{8'h00, 8'h0A, 8'h60};
    run_frame(8'h6A, 1'b0, -1);
    res("reload", 1'b1, 1'b0, 2'b00, 8'd2);

    pay = '{8'h20, 8'hD0, 8'h60};
    for (int r = 0; r < 3; r++) begin
      run_frame(8'h50, 1'b1, -1);
      res("bp_wrap", 1'b1, 1'b0, 2'b00, 8'd3);
    end

    w0 = wr_cnt;
    send(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("zero.writes", wr_cnt - w0, 0);
    res("zero", 1'b0, 1'b1, 2'b11, 8'd0);

    send(8'd5, 1'b0);
    sb.push_back({BASE, 8'h11});
    send(8'h11, 1'b0);
    repeat (2) @(negedge clk);
    chk("mid.busy", bus.busy, 1'b1);
    chk("mid.sb", sb.size(), 0);
    rst = 1'b1;
    #1;
    reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pay = '{8'h00, 8'h0A, 8'h60};
    run_frame(8'h6A, 1'b0, -1);
    res("post_rst", 1'b1, 1'b0, 2'b00, 8'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
